// File: rtl/pair_unpack_fifo.sv
// pair_unpack_fifo
//   Show-ahead FIFO of packed pair words. Each 8-bit entry carries two 4-bit
//   fields: [3:0] = a, [7:4] = b. The oldest entry is presented on out_a/out_b
//   (and optionally their sum) with no read latency. Outputs read as zero
//   whenever the FIFO is empty.
//
// Parameters
//   DEPTH      entry count, power of two in 2..16 (default 4)
//
// Build options
//   PAIR_UNPACK_SUM_EN  when defined, out_sum = out_a + out_b (5-bit);
//                       otherwise out_sum is tied to zero and no adder exists.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   producer offers in_data
//   in_data    in   [7:0] packed pair word
//   in_ready   out  FIFO not full
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer takes the head entry
//   out_a      out  [3:0] a field of head entry
//   out_b      out  [3:0] b field of head entry
//   out_sum    out  [4:0] a+b of head entry (zero without PAIR_UNPACK_SUM_EN)
//   level      out  current entry count, $clog2(DEPTH)+1 bits

module pair_unpack_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_a,
  output logic [3:0]             out_b,
  output logic [4:0]             out_sum,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;

  // Full/empty come only from the registered level, so neither handshake
  // output has a combinational path from the opposite side.
  assign w_full   = (r_level == LVL_FULL);
  assign w_empty  = (r_level == '0);
  assign in_ready  = ~w_full;
  assign out_valid = ~w_empty;

  assign w_push = in_valid  & ~w_full;
  assign w_pop  = out_ready & ~w_empty;

  assign w_wptr_nxt = (r_wptr == PTR_LAST) ? '0 : r_wptr + PTR_ONE;
  assign w_rptr_nxt = (r_rptr == PTR_LAST) ? '0 : r_rptr + PTR_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= w_wptr_nxt;
      if (w_pop)  r_rptr <= w_rptr_nxt;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset; the rst_n gate keeps an edge seen during reset
  // from writing, although stale data would be masked by out_valid anyway.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_mem[r_wptr] <= in_data;
  end

  assign w_head = r_mem[r_rptr];
  assign out_a  = out_valid ? w_head[3:0] : '0;
  assign out_b  = out_valid ? w_head[7:4] : '0;
  assign level  = r_level;

`ifdef PAIR_UNPACK_SUM_EN
  // out_a/out_b are already masked, so the sum reads zero when empty.
  assign out_sum = {1'b0, out_a} + {1'b0, out_b};
`else
  assign out_sum = '0;
`endif

endmodule

// File: tb/tb_pair_unpack_fifo.sv
module tb_pair_unpack_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_a;
  logic [3:0]    out_b;
  logic [4:0]    out_sum;
  logic [LW-1:0] level;

  int pass_cnt = 0;
  int total    = 0;

  pair_unpack_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_sum   (out_sum),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Reference: a queue of accepted words, oldest at index 0.
  logic [7:0] q[$];

  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      automatic bit do_pop  = (q.size() > 0) && (out_ready === 1'b1);
      automatic bit do_push = (q.size() < DEPTH) && (in_valid === 1'b1);
      automatic logic [7:0] d = in_data;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
  end

  function automatic int exp_sum(logic [7:0] w);
`ifdef PAIR_UNPACK_SUM_EN
    return int'(w[3:0]) + int'(w[7:4]);
`else
    return 0;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  // Per-cycle comparison of every output against the queue model.
  always @(negedge clk) begin
    automatic logic [7:0] h = (q.size() > 0) ? q[0] : 8'h00;
    check("mdl_level",     32'(level),     32'(q.size()));
    check("mdl_out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("mdl_in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
    check("mdl_out_a",     32'(out_a),     32'(h[3:0]));
    check("mdl_out_b",     32'(out_b),     32'(h[7:4]));
    check("mdl_out_sum",   32'(out_sum),   32'(exp_sum(h)));
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int sum_a5;
  int sum_ff;

  initial begin
`ifdef PAIR_UNPACK_SUM_EN
    sum_a5 = 15;
    sum_ff = 30;
`else
    sum_a5 = 0;
    sum_ff = 0;
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    check("rst_level",     32'(level),     0);
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    step();

    // Single push of A5.
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    check("a5_out_valid", 32'(out_valid), 1);
    check("a5_out_a",     32'(out_a),     32'h5);
    check("a5_out_b",     32'(out_b),     32'hA);
    check("a5_out_sum",   32'(out_sum),   32'(sum_a5));
    check("a5_level",     32'(level),     1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("a5_drained", 32'(level), 0);

    // Fill to full, offer FF while full, then drain.
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    check("full_level",    32'(level),    4);
    check("full_in_ready", 32'(in_ready), 0);
    in_data = 8'hFF;
    step(); step();
    check("full_hold_level", 32'(level), 4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_out_a", 32'(out_a), 32'(i));
      check("drain_out_b", 32'(out_b), 0);
      step();
    end
    out_ready = 1'b0;
    check("drain_level", 32'(level), 0);
    check("drain_valid", 32'(out_valid), 0);

    // Steady push+pop at level 2 across pointer wraps.
    in_valid = 1'b1;
    in_data = 8'h10; step();
    in_data = 8'h11; step();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = 8'(8'h12 + k);
      check("stream_level", 32'(level), 2);
      check("stream_out_a", 32'(out_a), 32'((8'h10 + k) & 8'h0F));
      step();
    end
    in_valid = 1'b0;
    check("stream_end_level", 32'(level), 2);
    check("stream_end_a",     32'(out_a), 32'h0A);
    check("stream_end_b",     32'(out_b), 32'h1);
    step(); step();
    out_ready = 1'b0;

    // FF: maximum sum.
    in_valid = 1'b1; in_data = 8'hFF;
    step();
    in_valid = 1'b0;
    check("ff_out_sum", 32'(out_sum), 32'(sum_ff));
    out_ready = 1'b1;
    step();

    // Pop attempts on empty.
    for (int k = 0; k < 3; k++) begin
      step();
      check("empty_pop_level", 32'(level),     0);
      check("empty_pop_valid", 32'(out_valid), 0);
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h57;
    step();
    in_valid = 1'b0;
    check("after_empty_a", 32'(out_a), 32'h7);
    check("after_empty_b", 32'(out_b), 32'h5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Async reset with three entries buffered.
    in_valid = 1'b1;
    in_data = 8'h21; step();
    in_data = 8'h22; step();
    in_data = 8'h23; step();
    in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 3);
    #1 rst_n = 1'b0;
    #1;
    check("arst_level",     32'(level),     0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_in_ready",  32'(in_ready),  1);
    check("arst_out_a",     32'(out_a),     0);
    check("arst_out_b",     32'(out_b),     0);
    check("arst_out_sum",   32'(out_sum),   0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    check("post_rst_a",     32'(out_a), 32'hC);
    check("post_rst_b",     32'(out_b), 32'h3);
    check("post_rst_level", 32'(level), 1);
    out_ready = 1'b1;
    step();

    // Mixed traffic, checked by the model.
    for (int k = 0; k < 60; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) step();
    check("final_level", 32'(level), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pair_unpack_fifo.md
PAIR_UNPACK_FIFO -- requirements
Module: pair_unpack_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entry count (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  producer offers in_data this cycle.
REQ-005 The block SHALL have port in_data  input  8  packed pair word, [7:4]=b field, [3:0]=a field.
REQ-006 The block SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 The block SHALL have port out_valid  output  1  head entry available.
REQ-008 The block SHALL have port out_ready  input  1  consumer takes head entry this cycle.
REQ-009 The block SHALL have port out_a  output  4  a field of head entry.
REQ-010 The block SHALL have port out_b  output  4  b field of head entry.
REQ-011 The block SHALL have port out_sum  output  5  a+b of head entry (see Configuration).
REQ-012 The block SHALL have port level  output  $clog2(DEPTH)+1  current entry count.

Function
REQ-013 Push SHALL occur when in_valid and in_ready are both 1 at a rising clk edge; pop SHALL occur when out_valid and out_ready are both 1.
REQ-014 in_ready SHALL equal (level != DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (level != 0), derived from registered state only.
REQ-016 Storage SHALL be first-in first-out; out_a/out_b SHALL be the [3:0]/[7:4] fields of the oldest entry, show-ahead, with no read-enable latency.
REQ-017 Latency SHALL be one cycle: a word pushed at edge N SHALL appear on the outputs with out_valid=1 after edge N if the FIFO was empty.
REQ-018 Write and read pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 with no skipped entry.
REQ-019 Simultaneous push and pop SHALL leave level unchanged, advance both pointers, and preserve ordering.
REQ-020 When level==DEPTH, in_valid SHALL be ignored and storage SHALL be unmodified; when level==0, out_ready SHALL be ignored.
REQ-021 When out_valid==0, out_a, out_b, and out_sum SHALL be driven 0.
REQ-022 level SHALL change by at most 1 per cycle: +1 on push only, -1 on pop only.
REQ-023 Holding in_valid with in_ready=0 SHALL NOT require in_data to be retained by the block; the producer keeps it stable until accepted.

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately and asynchronously clear both pointers and level to 0, forcing out_valid=0, in_ready=1, out_a=0, out_b=0, out_sum=0, level=0.
REQ-025 Storage array contents SHALL NOT require reset; stale entries SHALL never be visible because out_valid=0 masks outputs.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered entries; the first push after rst_n deasserts SHALL be the first entry popped.
REQ-027 Release of rst_n SHALL be treated by the block as taking effect at the next rising clk edge, with no push or pop on that edge's reset-active cycle.

Configuration
REQ-028 With macro PAIR_UNPACK_SUM_EN defined, out_sum SHALL equal zero-extended out_a plus zero-extended out_b (5-bit, no overflow) for the head entry, combinationally.
REQ-029 Without PAIR_UNPACK_SUM_EN, out_sum SHALL be tied to 5'd0 and no adder logic SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-030 Reset then single push in_data=8'hA5 -> next cycle out_valid=1, out_a=4'h5, out_b=4'hA, out_sum=5'd15 (SUM_EN) or 0, level=1.
REQ-031 DEPTH=4, push 8'h01,8'h02,8'h03,8'h04 with out_ready=0 -> level=4, in_ready=0; fifth word 8'hFF offered, then popped 4 entries -> a fields 1,2,3,4, 8'hFF never appears.
REQ-032 Continuous push and pop at level=2 for 10 cycles with incrementing data 8'h10.. -> level stays 2, outputs in order, pointers wrap twice without loss.
REQ-033 Fill with 3 entries, assert rst_n=0 asynchronously mid-cycle -> outputs zero and level=0 before next clk edge; after release push 8'h3C -> out_a=4'hC, out_b=4'h3.
REQ-034 Push 8'hFF with SUM_EN defined -> out_sum=5'd30; without the macro -> out_sum=0.
REQ-035 Pop attempt with out_ready=1 on empty FIFO for 3 cycles -> level stays 0, out_valid=0, no pointer movement.
